// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : 5-stage pipeline stall / flush / redirect sequencing controller
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int MDU_MAX = 40,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic              id_rs1_use_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic              id_rs2_use_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              ex_load_i,
   input  logic              ex_jump_i,
   input  logic [ADDR_W-1:0] ex_jump_addr_i,
   input  logic              ex_mdu_start_i,
   input  logic              mdu_done_i,
   input  logic              mem_req_i,
   input  logic              mem_ready_i,
   input  logic              int_req_i,
   input  logic [ADDR_W-1:0] int_addr_i,
   output logic              stall_pc_o,
   output logic              stall_if_id_o,
   output logic              stall_id_ex_o,
   output logic              stall_ex_mem_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              flush_ex_mem_o,
   output logic              jump_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              int_ack_o,
   output logic              mdu_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int              WD_W    = $clog2(MDU_MAX + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_MAX - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MDU_WAIT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_freeze;
   logic              load_use;
   logic              wd_last;

   always_comb begin
      mem_freeze = mem_req_i && !mem_ready_i;
      load_use   = ex_load_i && (ex_rd_addr_i != '0) &&
                   ((id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                    (id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i)));
      wd_last    = (wd_q >= WD_LAST);

      state_d        = state_q;
      wd_d           = wd_q;
      stall_pc_o     = 1'b0;
      stall_if_id_o  = 1'b0;
      stall_id_ex_o  = 1'b0;
      stall_ex_mem_o = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      flush_ex_mem_o = 1'b0;
      jump_o         = 1'b0;
      jump_addr_o    = '0;
      int_ack_o      = 1'b0;
      mdu_timeout_o  = 1'b0;

      if (mem_freeze) begin
         stall_pc_o     = 1'b1;
         stall_if_id_o  = 1'b1;
         stall_id_ex_o  = 1'b1;
         stall_ex_mem_o = 1'b1;
         if (state_q == RUN) state_d = MEM_WAIT;
         // The MDU keeps running while the bus is frozen, so the watchdog does too;
         // it parks one short of the limit and fires on the first unfrozen cycle.
         if ((state_q == MDU_WAIT) && !wd_last) wd_d = wd_q + 1'b1;
      end else if (state_q == MDU_WAIT) begin
         if (mdu_done_i) begin
            state_d = RUN;
         end else if (wd_last) begin
            mdu_timeout_o = 1'b1;
            state_d       = RUN;
         end else begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            wd_d           = wd_q + 1'b1;
         end
      end else begin
         // RUN, or the MEM_WAIT release cycle which behaves exactly like RUN
         state_d = RUN;
         if (ex_jump_i) begin
            jump_o        = 1'b1;
            jump_addr_o   = ex_jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (ex_mdu_start_i) begin
            stall_pc_o     = 1'b1;
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            state_d        = MDU_WAIT;
            wd_d           = '0;
         end else if (load_use) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (int_req_i) begin
            jump_o        = 1'b1;
            jump_addr_o   = int_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            int_ack_o     = 1'b1;
         end
      end

      if (!rst_n) begin
         stall_pc_o     = 1'b0;
         stall_if_id_o  = 1'b0;
         stall_id_ex_o  = 1'b0;
         stall_ex_mem_o = 1'b0;
         flush_if_id_o  = 1'b0;
         flush_id_ex_o  = 1'b0;
         flush_ex_mem_o = 1'b0;
         jump_o         = 1'b0;
         jump_addr_o    = '0;
         int_ack_o      = 1'b0;
         mdu_timeout_o  = 1'b0;
      end

      cnt_d = cnt_q;
      if (stall_pc_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      stall_cnt_o = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_rs1_use, id_rs2_use, ex_load, ex_jump, ex_mdu_start;
   logic        mdu_done, mem_req, mem_ready, int_req;
   logic [31:0] ex_jump_addr, int_addr;

   logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
   logic        flush_if_id, flush_id_ex, flush_ex_mem;
   logic        jump, int_ack, mdu_timeout;
   logic [31:0] jump_addr, stall_cnt;

   logic        d4_stall_pc, d4_stall_if_id, d4_stall_id_ex, d4_stall_ex_mem;
   logic        d4_flush_if_id, d4_flush_id_ex, d4_flush_ex_mem;
   logic        d4_jump, d4_int_ack, d4_mdu_timeout;
   logic [31:0] d4_jump_addr;
   logic [3:0]  d4_stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(id_rs1_addr), .id_rs1_use_i(id_rs1_use),
      .id_rs2_addr_i(id_rs2_addr), .id_rs2_use_i(id_rs2_use),
      .ex_rd_addr_i(ex_rd_addr), .ex_load_i(ex_load),
      .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
      .ex_mdu_start_i(ex_mdu_start), .mdu_done_i(mdu_done),
      .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .int_req_i(int_req), .int_addr_i(int_addr),
      .stall_pc_o(stall_pc), .stall_if_id_o(stall_if_id),
      .stall_id_ex_o(stall_id_ex), .stall_ex_mem_o(stall_ex_mem),
      .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
      .flush_ex_mem_o(flush_ex_mem), .jump_o(jump), .jump_addr_o(jump_addr),
      .int_ack_o(int_ack), .mdu_timeout_o(mdu_timeout), .stall_cnt_o(stall_cnt)
   );

   pipe_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr_i(id_rs1_addr), .id_rs1_use_i(id_rs1_use),
      .id_rs2_addr_i(id_rs2_addr), .id_rs2_use_i(id_rs2_use),
      .ex_rd_addr_i(ex_rd_addr), .ex_load_i(ex_load),
      .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
      .ex_mdu_start_i(ex_mdu_start), .mdu_done_i(mdu_done),
      .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .int_req_i(int_req), .int_addr_i(int_addr),
      .stall_pc_o(d4_stall_pc), .stall_if_id_o(d4_stall_if_id),
      .stall_id_ex_o(d4_stall_id_ex), .stall_ex_mem_o(d4_stall_ex_mem),
      .flush_if_id_o(d4_flush_if_id), .flush_id_ex_o(d4_flush_id_ex),
      .flush_ex_mem_o(d4_flush_ex_mem), .jump_o(d4_jump), .jump_addr_o(d4_jump_addr),
      .int_ack_o(d4_int_ack), .mdu_timeout_o(d4_mdu_timeout), .stall_cnt_o(d4_stall_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_rs1_addr = '0; id_rs1_use = 1'b0; id_rs2_addr = '0; id_rs2_use = 1'b0;
      ex_rd_addr = '0; ex_load = 1'b0; ex_jump = 1'b0; ex_jump_addr = '0;
      ex_mdu_start = 1'b0; mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      int_req = 1'b0; int_addr = '0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      // Reset: outputs forced low even with jump/interrupt requested
      clr();
      rst_n = 1'b0;
      ex_jump = 1'b1; ex_jump_addr = 32'h55; int_req = 1'b1; int_addr = 32'h66;
      smp();
      chk("rst_jump", {63'd0, jump}, 64'd0);
      chk("rst_jump_addr", {32'd0, jump_addr}, 64'd0);
      chk("rst_flush_if_id", {63'd0, flush_if_id}, 64'd0);
      chk("rst_int_ack", {63'd0, int_ack}, 64'd0);
      chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
      nxt(); clr(); rst_n = 1'b1;

      // Load-use on rs1
      ex_load = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_use = 1'b1;
      smp();
      chk("lu_stall_pc", {63'd0, stall_pc}, 64'd1);
      chk("lu_stall_if_id", {63'd0, stall_if_id}, 64'd1);
      chk("lu_flush_id_ex", {63'd0, flush_id_ex}, 64'd1);
      chk("lu_stall_id_ex", {63'd0, stall_id_ex}, 64'd0);
      chk("lu_flush_ex_mem", {63'd0, flush_ex_mem}, 64'd0);
      nxt(); clr();
      smp();
      chk("lu_after_stall_pc", {63'd0, stall_pc}, 64'd0);
      chk("lu_after_flush_id_ex", {63'd0, flush_id_ex}, 64'd0);
      chk("lu_cnt", {32'd0, stall_cnt}, 64'd1);

      // rd = x0 never hazards
      nxt();
      ex_load = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs1_use = 1'b1;
      smp();
      chk("lu_x0_stall_pc", {63'd0, stall_pc}, 64'd0);
      // rs2 match
      nxt(); clr();
      ex_load = 1'b1; ex_rd_addr = 5'd7; id_rs2_addr = 5'd7; id_rs2_use = 1'b1;
      smp();
      chk("lu_rs2_stall_pc", {63'd0, stall_pc}, 64'd1);
      // rs2 match but operand unused
      nxt(); id_rs2_use = 1'b0;
      smp();
      chk("lu_rs2_unused", {63'd0, stall_pc}, 64'd0);
      chk("lu_cnt2", {32'd0, stall_cnt}, 64'd2);

      // Jump beats load-use and interrupt
      nxt(); clr();
      ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100; int_req = 1'b1; int_addr = 32'h80;
      ex_load = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs1_use = 1'b1;
      smp();
      chk("jmp_jump", {63'd0, jump}, 64'd1);
      chk("jmp_addr", {32'd0, jump_addr}, 64'h100);
      chk("jmp_flush_if_id", {63'd0, flush_if_id}, 64'd1);
      chk("jmp_flush_id_ex", {63'd0, flush_id_ex}, 64'd1);
      chk("jmp_stall_pc", {63'd0, stall_pc}, 64'd0);
      chk("jmp_int_ack", {63'd0, int_ack}, 64'd0);

      // Interrupt on a clean RUN cycle
      nxt(); clr(); int_req = 1'b1; int_addr = 32'h80;
      smp();
      chk("int_ack", {63'd0, int_ack}, 64'd1);
      chk("int_addr", {32'd0, jump_addr}, 64'h80);
      chk("int_flush_id_ex", {63'd0, flush_id_ex}, 64'd1);
      nxt(); clr();
      smp();
      chk("idle_jump_addr", {32'd0, jump_addr}, 64'd0);

      // Clear the counters before the MDU runs
      nxt(); rst_n = 1'b0;
      nxt(); rst_n = 1'b1;

      // MDU: start cycle plus 9 wait cycles stall, done on the 11th
      ex_mdu_start = 1'b1;
      smp();
      chk("mdu_start_stall_pc", {63'd0, stall_pc}, 64'd1);
      chk("mdu_start_stall_id_ex", {63'd0, stall_id_ex}, 64'd1);
      chk("mdu_start_flush_ex_mem", {63'd0, flush_ex_mem}, 64'd1);
      chk("mdu_start_stall_ex_mem", {63'd0, stall_ex_mem}, 64'd0);
      nxt(); clr();
      for (int i = 0; i < 9; i++) begin
         smp();
         chk("mdu_wait_stall", {62'd0, stall_pc, flush_ex_mem}, 64'd3);
         nxt();
      end
      mdu_done = 1'b1;
      smp();
      chk("mdu_done_stall_pc", {63'd0, stall_pc}, 64'd0);
      chk("mdu_done_flush_ex_mem", {63'd0, flush_ex_mem}, 64'd0);
      chk("mdu_cnt10", {32'd0, stall_cnt}, 64'd10);

      // MDU watchdog: start + 39 stalled waits, timeout on the 40th wait cycle
      nxt(); clr(); ex_mdu_start = 1'b1;
      nxt(); clr();
      for (int i = 0; i < 39; i++) begin
         smp();
         chk("wd_wait", {62'd0, stall_pc, mdu_timeout}, 64'd2);
         nxt();
      end
      smp();
      chk("wd_timeout", {63'd0, mdu_timeout}, 64'd1);
      chk("wd_timeout_stall_pc", {63'd0, stall_pc}, 64'd0);
      chk("wd_cnt50", {32'd0, stall_cnt}, 64'd50);
      chk("sat_cnt4", {60'd0, d4_stall_cnt}, 64'd15);
      nxt(); int_req = 1'b1; int_addr = 32'h44;
      smp();
      chk("wd_after_timeout", {62'd0, mdu_timeout, int_ack}, 64'd1);

      // Memory freeze with pending interrupt
      nxt(); clr();
      mem_req = 1'b1; mem_ready = 1'b0; int_req = 1'b1; int_addr = 32'h200;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("mem_freeze_stalls",
             {60'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem}, 64'hF);
         chk("mem_freeze_ack_jump", {62'd0, int_ack, jump}, 64'd0);
         nxt();
      end
      mem_ready = 1'b1;
      smp();
      chk("mem_rel_int_ack", {63'd0, int_ack}, 64'd1);
      chk("mem_rel_jump_addr", {32'd0, jump_addr}, 64'h200);
      chk("mem_rel_stall_pc", {63'd0, stall_pc}, 64'd0);
      chk("mem_rel_stall_ex_mem", {63'd0, stall_ex_mem}, 64'd0);
      chk("sat_hold", {60'd0, d4_stall_cnt}, 64'd15);

      // Reset in the middle of MDU_WAIT
      nxt(); clr(); ex_mdu_start = 1'b1;
      nxt(); clr();
      nxt(); nxt();
      smp();
      chk("mid_mdu_stall_pc", {63'd0, stall_pc}, 64'd1);
      nxt(); rst_n = 1'b0;
      smp();
      chk("rst_mid_outputs", {56'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                              flush_if_id, flush_id_ex, flush_ex_mem, jump}, 64'd0);
      chk("rst_mid_cnt", {32'd0, stall_cnt}, 64'd0);
      nxt(); rst_n = 1'b1; int_req = 1'b1; int_addr = 32'h300;
      smp();
      chk("post_rst_run", {62'd0, stall_pc, int_ack}, 64'd1);
      chk("post_rst_addr", {32'd0, jump_addr}, 64'h300);
      nxt(); clr();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Decides every cycle which pipeline registers hold, which get a bubble, and where the PC is redirected.
- Covers the hazards the register/CSR forwarding path cannot resolve: load-use, multi-cycle MDU ops, data-bus wait states, taken jumps/branches and interrupt entry.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
ADDR_W, 32, PC / jump address width
REG_AW, 5, register address width
MDU_MAX, 40, MDU watchdog limit in cycles
CNT_W, 32, stall counter width

Ports:
clk  in  1  core clock
rst_n  in  1  reset
id_rs1_addr_i  in  REG_AW  rs1 of the instruction in ID
id_rs1_use_i  in  1  ID instruction reads rs1
id_rs2_addr_i  in  REG_AW  rs2 of the instruction in ID
id_rs2_use_i  in  1  ID instruction reads rs2
ex_rd_addr_i  in  REG_AW  rd of the instruction in EX
ex_load_i  in  1  EX instruction is a load
ex_jump_i  in  1  EX resolved a taken branch or jump
ex_jump_addr_i  in  ADDR_W  redirect target
ex_mdu_start_i  in  1  multi-cycle mul/div starts in EX (single-cycle pulse)
mdu_done_i  in  1  MDU result valid
mem_req_i  in  1  MEM stage data-bus request
mem_ready_i  in  1  data-bus ready
int_req_i  in  1  interrupt request (level)
int_addr_i  in  ADDR_W  trap vector
stall_pc_o  out  1  hold PC
stall_if_id_o  out  1  hold IF/ID
stall_id_ex_o  out  1  hold ID/EX
stall_ex_mem_o  out  1  hold EX/MEM
flush_if_id_o  out  1  IF/ID becomes NOP
flush_id_ex_o  out  1  ID/EX becomes NOP (bubble)
flush_ex_mem_o  out  1  EX/MEM becomes NOP
jump_o  out  1  PC redirect
jump_addr_o  out  ADDR_W  redirect target
int_ack_o  out  1  interrupt taken (1-cycle pulse)
mdu_timeout_o  out  1  watchdog fired (1-cycle pulse)
stall_cnt_o  out  CNT_W  stall cycle counter

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low.
- While rst_n is low: state=RUN, counters=0, and every output is 0, including jump_addr_o.
- States:
  - RUN: normal issue.
  - MEM_WAIT: data bus stalled.
  - MDU_WAIT: multi-cycle op in flight.
- Outputs are combinational from state and inputs. Evaluate the conditions below in the listed priority order; the first match applies.
  1. Mem freeze (any state): mem_req_i && !mem_ready_i.
     - Assert all four stall_* outputs. All flushes and jump_o are 0.
     - In RUN, the next state is MEM_WAIT. In MEM_WAIT, hold. In MDU_WAIT, remain in MDU_WAIT.
  2. MEM_WAIT && mem_ready_i: release all stalls this cycle and go to RUN. Conditions 3-6 are then evaluated as in RUN.
  3. MDU_WAIT && !mdu_done_i:
     - Assert stall_pc_o, stall_if_id_o, stall_id_ex_o and flush_ex_mem_o.
     - MDU_WAIT && mdu_done_i: no stall; go to RUN.
     - The watchdog counts cycles spent in MDU_WAIT. When it reaches MDU_MAX without mdu_done_i: pulse mdu_timeout_o, release stalls, go to RUN.
  4. RUN && ex_jump_i:
     - jump_o=1, jump_addr_o=ex_jump_addr_i.
     - flush_if_id_o=1, flush_id_ex_o=1.
     - Load-use and interrupt are suppressed.
  5. RUN && ex_mdu_start_i: enter MDU_WAIT next cycle. The current cycle applies the rules of condition 3.
  6. RUN, load-use: ex_load_i && ex_rd_addr_i!=0 && ((id_rs1_use_i && rs1==rd) || (id_rs2_use_i && rs2==rd)).
     - stall_pc_o=1, stall_if_id_o=1, flush_id_ex_o=1 for exactly one cycle.
     - The next cycle sees the load in MEM, so the hazard clears.
  7. RUN, no other condition, int_req_i=1:
     - jump_o=1, jump_addr_o=int_addr_i, flush_if_id_o=1, flush_id_ex_o=1, int_ack_o=1.
     - An interrupt is never taken in MEM_WAIT or MDU_WAIT. It waits for a clean RUN cycle.
- Outputs not driven by the matching condition are 0. jump_addr_o is 0 whenever jump_o=0.
- stall_cnt_o increments on every cycle stall_pc_o=1 and saturates at all-ones (no wrap).
- The watchdog counter resets to 0 on entry to MDU_WAIT.
- Reset asserted mid-operation (any state) returns immediately to RUN with all outputs 0. An in-flight MDU op is abandoned.

Test Plan:
- Load-use: EX load rd=5; ID rs1=5, use=1 → one cycle of stall_pc/stall_if_id/flush_id_ex; cycle after, all 0; stall_cnt_o=1. Repeat with rd=0 → no stall.
- Jump and load-use in the same cycle: ex_jump_i=1, addr=0x0000_0100 → jump_o=1, jump_addr_o=0x100, flush_if_id=flush_id_ex=1, stall_pc=0.
- MDU: start pulse, mdu_done_i after 10 cycles → 10 stall cycles with flush_ex_mem=1, then RUN. Second run with no done → mdu_timeout_o pulse at cycle 40, stall_cnt_o=50 total.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 3 cycles with int_req_i=1 → 3 freeze cycles, int_ack_o=0; on ready → int_ack_o=1, jump_addr_o=int_addr_i.
- Counter saturation with CNT_W=4: 20 stall cycles → stall_cnt_o=15. Reset asserted mid MDU_WAIT → all outputs 0, state RUN after release.
